// File: rtl/x_format_pkg.sv
// Shared definitions for the X-format pipeline: opcode constants, ALU op
// encoding, the S1 stage record and the PO/XO decoder.
package x_format_pkg;

    localparam logic [5:0] PO_X    = 6'd31;
    localparam logic [8:0] XO_AND  = 9'd28;
    localparam logic [8:0] XO_OR   = 9'd444;
    localparam logic [8:0] XO_XOR  = 9'd316;
    localparam logic [8:0] XO_NAND = 9'd476;
    localparam logic [8:0] XO_NOR  = 9'd124;
    localparam logic [8:0] XO_ADD  = 9'd266;
    localparam logic [8:0] XO_SUBF = 9'd40;
    localparam logic [8:0] XO_SLD  = 9'd27;
    localparam logic [8:0] XO_SRD  = 9'd283;

    typedef enum logic [3:0] {
        AND, OR, XOR, NAND, NOR, ADD, SUBF, SLD, SRD, ILLEGAL
    } alu_op_e;

    typedef struct packed {
        alu_op_e    op;
        logic [4:0] rs;
        logic [4:0] ra;
        logic [4:0] rb;
        logic       oe;
        logic       rc;
    } s1_t;

    function automatic alu_op_e decode(input logic [5:0] po, input logic [8:0] xo);
        alu_op_e op;
        op = ILLEGAL;
        if (po == PO_X) begin
            case (xo)
                XO_AND:  op = AND;
                XO_OR:   op = OR;
                XO_XOR:  op = XOR;
                XO_NAND: op = NAND;
                XO_NOR:  op = NOR;
                XO_ADD:  op = ADD;
                XO_SUBF: op = SUBF;
                XO_SLD:  op = SLD;
                XO_SRD:  op = SRD;
                default: op = ILLEGAL;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/xf_alu.sv
// Combinational X-format ALU: a = rs operand, b = rb operand.
// Overflow is signed and only meaningful for ADD/SUBF.
module xf_alu
    import x_format_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  alu_op_e         i_op,
    output logic [XLEN-1:0] o_result,
    output logic            o_ovf
);
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_b - i_a;

    always_comb begin
        o_result = '0;
        o_ovf    = 1'b0;
        case (i_op)
            AND:  o_result = i_a & i_b;
            OR:   o_result = i_a | i_b;
            XOR:  o_result = i_a ^ i_b;
            NAND: o_result = ~(i_a & i_b);
            NOR:  o_result = ~(i_a | i_b);
            ADD: begin
                o_result = w_sum;
                o_ovf    = (i_a[XLEN-1] == i_b[XLEN-1]) && (w_sum[XLEN-1] != i_a[XLEN-1]);
            end
            SUBF: begin
                o_result = w_diff;
                o_ovf    = (i_a[XLEN-1] != i_b[XLEN-1]) && (w_diff[XLEN-1] != i_b[XLEN-1]);
            end
            // bit 6 of the shift amount forces a zero result
            SLD:  o_result = i_b[6] ? '0 : (i_a << i_b[5:0]);
            SRD:  o_result = i_b[6] ? '0 : (i_a >> i_b[5:0]);
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/x_format_pipe.sv
// Two-stage X-format execute pipe with GPR file, CR0 and XER[SO].
// S1 reads operands (with S2 bypass), S2 holds the result until write-back.
module x_format_pipe
    import x_format_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int RAW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      in_po,
    input  logic [4:0]      in_rs,
    input  logic [4:0]      in_ra,
    input  logic [4:0]      in_rb,
    input  logic [8:0]      in_xo,
    input  logic            in_oe,
    input  logic            in_rc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_ra,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal,
    output logic [3:0]      cr0,
    output logic            xer_so
);
    logic [XLEN-1:0] r_gpr [NREG];
    s1_t             r_s1;
    logic            r_s1_valid;
    logic            r_s2_valid;
    logic [4:0]      r_s2_ra;
    logic [XLEN-1:0] r_s2_result;
    logic            r_s2_illegal;
    logic            r_s2_ovf;
    logic            r_s2_rc;
    logic [3:0]      r_cr0;
    logic            r_xer_so;

    logic            w_wb, w_s2_adv, w_s1_adv, w_acc, w_byp;
    logic [XLEN-1:0] w_a, w_b, w_alu_res;
    logic            w_alu_ovf, w_so_new, w_lt, w_eq, w_gt;

    assign w_wb     = r_s2_valid && out_ready;
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = !reset && w_s1_adv;
    assign w_acc    = in_valid && in_ready;

    // S2 forwards whether stalled or retiring this edge
    assign w_byp = r_s2_valid && !r_s2_illegal;
    assign w_a = (w_byp && r_s2_ra[RAW-1:0] == r_s1.rs[RAW-1:0]) ? r_s2_result
                                                                   : r_gpr[r_s1.rs[RAW-1:0]];
    assign w_b = (w_byp && r_s2_ra[RAW-1:0] == r_s1.rb[RAW-1:0]) ? r_s2_result
                                                                   : r_gpr[r_s1.rb[RAW-1:0]];

    xf_alu #(.XLEN(XLEN)) u_alu (
        .i_a      (w_a),
        .i_b      (w_b),
        .i_op     (r_s1.op),
        .o_result (w_alu_res),
        .o_ovf    (w_alu_ovf)
    );

    assign w_so_new = r_xer_so | r_s2_ovf;
    assign w_lt     = r_s2_result[XLEN-1];
    assign w_eq     = (r_s2_result == '0);
    assign w_gt     = !w_lt && !w_eq;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_gpr[i] <= XLEN'(i);
            r_s1         <= '0;
            r_s1_valid   <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_s2_ra      <= '0;
            r_s2_result  <= '0;
            r_s2_illegal <= 1'b0;
            r_s2_ovf     <= 1'b0;
            r_s2_rc      <= 1'b0;
            r_cr0        <= '0;
            r_xer_so     <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_ra      <= r_s1.ra;
                    r_s2_result  <= w_alu_res;
                    r_s2_illegal <= (r_s1.op == ILLEGAL);
                    r_s2_ovf     <= w_alu_ovf && r_s1.oe;
                    r_s2_rc      <= r_s1.rc;
                end
            end
            if (w_s1_adv) begin
                r_s1_valid <= w_acc;
                if (w_acc)
                    r_s1 <= '{op: decode(in_po, in_xo), rs: in_rs, ra: in_ra,
                              rb: in_rb, oe: in_oe, rc: in_rc};
            end
            if (w_wb && !r_s2_illegal) begin
                r_gpr[r_s2_ra[RAW-1:0]] <= r_s2_result;
                r_xer_so <= w_so_new;
                if (r_s2_rc) r_cr0 <= {w_lt, w_gt, w_eq, w_so_new};
            end
        end
    end

    assign out_valid   = r_s2_valid;
    assign out_ra      = r_s2_ra;
    assign out_result  = r_s2_result;
    assign out_illegal = r_s2_illegal;
    assign cr0         = r_cr0;
    assign xer_so      = r_xer_so;

endmodule

// File: tb/tb_x_format_pipe.sv
// Bench for x_format_pipe: vector tables plus stall and reset sequences,
// with a queue of expected write-backs checked as outputs retire.
module tb_x_format_pipe;
    import x_format_pkg::*;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MAXP = {1'b0, {(XLEN-1){1'b1}}};
    localparam logic [XLEN-1:0] MINN = {1'b1, {(XLEN-1){1'b0}}};

    logic clk = 1'b0;
    logic reset, in_valid, in_ready, in_oe, in_rc;
    logic [5:0] in_po;
    logic [4:0] in_rs, in_ra, in_rb;
    logic [8:0] in_xo;
    logic out_valid, out_ready, out_illegal, xer_so;
    logic [4:0] out_ra;
    logic [XLEN-1:0] out_result;
    logic [3:0] cr0;

    x_format_pipe #(.XLEN(XLEN), .NREG(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_po(in_po), .in_rs(in_rs), .in_ra(in_ra), .in_rb(in_rb), .in_xo(in_xo),
        .in_oe(in_oe), .in_rc(in_rc), .out_valid(out_valid), .out_ready(out_ready),
        .out_ra(out_ra), .out_result(out_result), .out_illegal(out_illegal),
        .cr0(cr0), .xer_so(xer_so)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [5:0] po; logic [8:0] xo;
        logic [4:0] rs, ra, rb;
        logic oe, rc;
        logic [XLEN-1:0] res; logic ill; logic [3:0] cr; logic so;
    } vec_t;

    typedef struct {
        logic [4:0] ra; logic [XLEN-1:0] res; logic ill; logic chk_res;
        logic [3:0] cr; logic so; logic chk_lat; int acc;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[$];
    vec_t stl[$];
    vec_t post[$];
    int tests = 0, fails = 0, cyc = 0, n_acc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic vec_t V(input logic [5:0] po, input logic [8:0] xo,
                               input int rs, input int ra, input int rb,
                               input logic oe, input logic rc, input logic [XLEN-1:0] res,
                               input logic ill, input logic [3:0] cr, input logic so);
        vec_t v;
        v.po = po; v.xo = xo; v.rs = 5'(rs); v.ra = 5'(ra); v.rb = 5'(rb);
        v.oe = oe; v.rc = rc; v.res = res; v.ill = ill; v.cr = cr; v.so = so;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input vec_t v, input bit push, input bit lat);
        exp_t e;
        bit done;
        done = 1'b0;
        in_po = v.po; in_xo = v.xo; in_rs = v.rs; in_ra = v.ra; in_rb = v.rb;
        in_oe = v.oe; in_rc = v.rc; in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                if (push) begin
                    e.ra = v.ra; e.res = v.res; e.ill = v.ill; e.chk_res = !v.ill;
                    e.cr = v.cr; e.so = v.so; e.chk_lat = lat; e.acc = cyc + 1;
                    sbq.push_back(e);
                end
                n_acc++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sbq.size() != 0; k++) @(posedge clk);
        if (sbq.size() != 0) begin
            chk("drain_timeout", XLEN'(sbq.size()), 0);
            sbq.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output monitor: retire checks, CR0/XER one edge later, stall stability.
    initial begin
        exp_t e;
        bit pend, lv;
        logic [3:0] pcr;
        logic pso, lill;
        logic [4:0] lra;
        logic [XLEN-1:0] lres;
        pend = 1'b0; lv = 1'b0;
        forever begin
            @(negedge clk);
            if (pend && !reset) begin
                chk("cr0", XLEN'(cr0), XLEN'(pcr));
                chk("xer_so", XLEN'(xer_so), XLEN'(pso));
            end
            pend = 1'b0;
            if (!reset && out_valid && out_ready) begin
                if (sbq.size() == 0) chk("unexpected_output", 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk("out_ra", XLEN'(out_ra), XLEN'(e.ra));
                    chk("out_illegal", XLEN'(out_illegal), XLEN'(e.ill));
                    if (e.chk_res) chk("out_result", out_result, e.res);
                    if (e.chk_lat) chk("latency", XLEN'(cyc), XLEN'(e.acc + 1));
                    pend = 1'b1; pcr = e.cr; pso = e.so;
                end
            end
            if (!reset && out_valid && !out_ready) begin
                if (lv) begin
                    chk("stall_result", out_result, lres);
                    chk("stall_ra", XLEN'(out_ra), XLEN'(lra));
                    chk("stall_illegal", XLEN'(out_illegal), XLEN'(lill));
                end
                lv = 1'b1; lres = out_result; lra = out_ra; lill = out_illegal;
            end else lv = 1'b0;
        end
    end

    initial begin
        // Expected values assume in-order execution from GPR[i] = i.
        tbl.push_back(V(PO_X, XO_OR,   1,  3,  2, 0, 0, 64'd3,       0, 4'b0000, 0));
        tbl.push_back(V(PO_X, XO_ADD,  4,  5,  6, 0, 0, 64'd10,      0, 4'b0000, 0));
        tbl.push_back(V(PO_X, XO_SUBF, 5,  7,  6, 0, 1, -64'sd4,     0, 4'b1000, 0));
        tbl.push_back(V(PO_X, XO_AND,  7, 11, 13, 0, 0, 64'd12,      0, 4'b1000, 0));
        tbl.push_back(V(PO_X, XO_XOR, 11, 12,  5, 0, 1, 64'd6,       0, 4'b0100, 0));
        tbl.push_back(V(PO_X, XO_NAND, 3, 14,  3, 0, 1, ~64'd3,      0, 4'b1000, 0));
        tbl.push_back(V(PO_X, XO_NOR,  0,  8,  0, 0, 0, ONES,        0, 4'b1000, 0));
        tbl.push_back(V(PO_X, XO_SRD,  8,  9,  1, 0, 0, MAXP,        0, 4'b1000, 0));
        tbl.push_back(V(PO_X, XO_ADD,  9, 10,  1, 1, 1, MINN,        0, 4'b1001, 1));
        tbl.push_back(V(PO_X, XO_ADD,  8, 15,  1, 0, 1, 64'd0,       0, 4'b0011, 1));
        tbl.push_back(V(PO_X, XO_SLD,  1, 16, 20, 0, 0, 64'h100000,  0, 4'b0011, 1));
        tbl.push_back(V(PO_X, XO_SLD,  1, 18,  6, 0, 0, 64'd64,      0, 4'b0011, 1));
        tbl.push_back(V(PO_X, XO_SLD,  8, 19, 18, 0, 1, 64'd0,       0, 4'b0011, 1));
        tbl.push_back(V(PO_X, XO_SRD,  8, 20, 18, 0, 0, 64'd0,       0, 4'b0011, 1));
        tbl.push_back(V(PO_X, 9'(999), 1, 21,  2, 1, 1, 64'd0,       1, 4'b0011, 1));
        tbl.push_back(V(6'd30, XO_AND, 1, 22,  2, 0, 1, 64'd0,       1, 4'b0011, 1));
        tbl.push_back(V(PO_X, XO_OR,  21, 21, 21, 0, 0, 64'd21,      0, 4'b0011, 1));
        tbl.push_back(V(PO_X, XO_OR,  22, 22, 22, 0, 0, 64'd22,      0, 4'b0011, 1));
        tbl.push_back(V(PO_X, XO_OR,   5,  5,  5, 0, 0, 64'd10,      0, 4'b0011, 1));
        tbl.push_back(V(PO_X, XO_SRD, 14, 23, 20, 0, 0, ~64'd3,      0, 4'b0011, 1));
        tbl.push_back(V(PO_X, XO_ADD, 31, 25, 31, 0, 0, 64'd62,      0, 4'b0011, 1));
        tbl.push_back(V(PO_X, XO_ADD, 25, 25,  1, 0, 0, 64'd63,      0, 4'b0011, 1));
        tbl.push_back(V(PO_X, XO_SRD,  8, 26, 25, 0, 0, 64'd1,       0, 4'b0011, 1));
        tbl.push_back(V(PO_X, XO_SLD,  8, 27, 25, 0, 0, MINN,        0, 4'b0011, 1));

        stl.push_back(V(PO_X, XO_ADD,   3, 24,  5, 0, 0, 64'd13,     0, 4'b0011, 1));
        stl.push_back(V(PO_X, XO_ADD,  24, 28, 24, 0, 0, 64'd26,     0, 4'b0011, 1));
        stl.push_back(V(PO_X, XO_SUBF,  3, 29, 28, 0, 0, 64'd23,     0, 4'b0011, 1));

        // After reset: GPRs back to index, then a SUBF overflow from clean state.
        foreach (post[i]) post.delete();
        for (int r = 2; r <= 10; r++)
            post.push_back(V(PO_X, XO_OR, r, r, r, 0, 0, XLEN'(r), 0, 4'b0000, 0));
        post.push_back(V(PO_X, XO_NOR,  0,  8, 0, 0, 0, ONES,  0, 4'b0000, 0));
        post.push_back(V(PO_X, XO_SRD,  8,  9, 1, 0, 0, MAXP,  0, 4'b0000, 0));
        post.push_back(V(PO_X, XO_SUBF, 8, 11, 9, 1, 1, MINN,  0, 4'b1001, 1));

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_po = '0; in_xo = '0; in_rs = '0; in_ra = '0; in_rb = '0; in_oe = 1'b0; in_rc = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", XLEN'(out_valid), 0);
        chk("rst_in_ready", XLEN'(in_ready), 0);
        chk("rst_cr0", XLEN'(cr0), 0);
        chk("rst_xer_so", XLEN'(xer_so), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (tbl[i]) send(tbl[i], 1'b1, 1'b1);
        drain();

        // Back-pressure: two accepts fill the pipe, the third waits.
        out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                foreach (stl[i]) send(stl[i], 1'b1, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("stall_accepts", XLEN'(n_acc), 2);
                chk("stall_in_ready", XLEN'(in_ready), 0);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two instructions in flight that would write r2 and r3.
        out_ready = 1'b0;
        send(V(PO_X, XO_ADD, 1, 2, 30, 0, 1, 64'd0, 0, 4'b0000, 0), 1'b0, 1'b0);
        send(V(PO_X, XO_XOR, 1, 3, 1, 0, 1, 64'd0, 0, 4'b0000, 0), 1'b0, 1'b0);
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst2_in_ready", XLEN'(in_ready), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rst2_out_valid", XLEN'(out_valid), 0);
        chk("rst2_cr0", XLEN'(cr0), 0);
        chk("rst2_xer_so", XLEN'(xer_so), 0);

        foreach (post[i]) send(post[i], 1'b1, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/x_format_pipe.md
# x_format_pipe

Parametrised, pipelined successor to the single-cycle uPower X-format execution block. It holds the architectural GPR file, a CR0 field and an XER[SO] bit, and accepts one X-format instruction per cycle on a valid/ready handshake. Each instruction runs through a two-stage read/execute pipeline with S2→S1 operand bypass. Results are written back on an output handshake, and CR0 is updated for record (Rc=1) forms.

## Interface
Parameters:
- XLEN, 64, datapath and register width (≥8)
- NREG, 32, number of GPRs (power of two, ≤32)
- RAW, $clog2(NREG), register index width actually used from the 5-bit fields

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_po  in  6  primary opcode
- in_rs, in_ra, in_rb  in  5 each  source, destination, source fields; upper bits above RAW ignored
- in_xo  in  9  extended opcode
- in_oe  in  1  overflow-enable (add/subf only)
- in_rc  in  1  record bit
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_ra  out  5  destination index
- out_result  out  XLEN  ALU result
- out_illegal  out  1  unsupported PO/XO, so no architectural update
- cr0  out  4  {LT,GT,EQ,SO}
- xer_so  out  1  sticky summary overflow

## Operation
- Only PO=31 is legal. Supported XO values, with dest = ra:
  - AND=28: rs&rb
  - OR=444: rs|rb
  - XOR=316: rs^rb
  - NAND=476: ~(rs&rb)
  - NOR=124: ~(rs|rb)
  - ADD=266: rs+rb
  - SUBF=40: rb−rs
  - SLD=27: rs<<rb[6:0], result 0 if rb[6]
  - SRD=283: logical right shift with the same rule
- Any other PO/XO is illegal: the instruction still flows through the pipe and out_illegal=1, but there is no GPR, CR0 or XER write.
- Arithmetic is modulo 2^XLEN. Signed overflow applies to ADD/SUBF only, and sets xer_so (sticky) when in_oe=1.
- Rc=1 on a legal op sets CR0 from the signed result:
  - LT = result[XLEN-1]
  - GT = !LT && result≠0
  - EQ = result==0
  - SO = xer_so value after this instruction's update
- Stage S1 holds the accepted fields. Operands are read combinationally from the GPR file. If S2 is valid, legal, and S2.ra==S1.rs or S2.ra==S1.rb, the operand comes from S2.result instead. The ALU result is captured into S2.
- S2 drives the out_* ports. On out_valid && out_ready, a legal S2 writes GPR[ra], and CR0/xer_so if applicable, at that edge.
- in_ready = !s1_valid || !s2_valid || out_ready (single-entry stages, full throughput).
- Reset:
  - GPR[i] loads i.
  - cr0=0, xer_so=0.
  - s1_valid=s2_valid=0, so out_valid=0 and in_ready=0 during the reset cycle.
  - In-flight instructions are discarded with no write.

## Timing
- An instruction accepted at edge N appears on out_* after edge N+1 (out_valid high in cycle N+1→N+2), assuming no stall. Latency 2 edges to write-back, throughput 1/cycle.
- Stall: with out_valid && !out_ready:
  - S2 holds and all out_* stay stable.
  - S1 holds if valid.
  - in_ready=1 only while S1 is empty.
- Back-to-back dependent instructions need no bubbles. The bypass covers S2 both while stalled and on its write-back edge.
- Simultaneous write-back and S1 read of the same register: the bypass value wins and equals the value being written.
- cr0/xer_so outputs update one edge after the write-back handshake. CR0 SO reflects overflow from the same instruction.

## Structure
- Package x_format_pkg holds:
  - XO constants
  - PO_X=31
  - alu_op_e enum {AND,OR,XOR,NAND,NOR,ADD,SUBF,SLD,SRD,ILLEGAL}
  - a decode function (po,xo)→alu_op_e
- Sub-module xf_alu (combinational, XLEN-parametrised) takes (a,b,op) and returns (result, ovf).
- The top holds the GPR array, S1/S2 registers, bypass, handshake and CR0/XER.

## Test plan
- Reset then OR r3←r1|r2 (in_rc=0) → out_result=3, out_ra=3, 2 edges after accept; GPR3=3; cr0=0.
- ADD r5←r4+r6 immediately followed by SUBF r7←r6−r5 → second out_result=6−10=−4, with no bubble; SUBF with Rc=1 gives cr0=4'b1000.
- ADD with OE=1, rs=0x7FFF…F, rb=1 and Rc=1 → result 0x8000…0, xer_so=1, cr0=4'b1001; a later ADD with Rc=1 and result 0 gives cr0=4'b0011 (SO stays sticky).
- Hold out_ready=0 for 5 cycles with 3 instructions offered → in_ready drops after 2 accepts; out_* stay stable; all 3 results are correct and in order once released.
- PO=31, XO=999 → out_illegal=1 and the destination GPR is unchanged; PO=30, XO=28 → illegal as well.
- Assert reset while 2 instructions are in flight → out_valid=0 next cycle; GPRs equal their index; no write from the discarded instructions.
